// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the mac_block_gen slice: operand-packing mode
// encodings, default widths, and the mode -> active-lane-count mapping.
// ----------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        MAC_SINGLE = 2'd0,
        MAC_DUAL   = 2'd1,
        MAC_QUAD   = 2'd2,
        MAC_FULL   = 2'd3
    } mac_mode_e;

    localparam int MAC_MIN_W = 8;
    localparam int MAC_LANES = 4;
    localparam int MAC_ACC_W = 48;
    localparam int MAC_CNT_W = 8;

    // Number of top lanes that contribute to the packed product.
    function automatic int mode_lanes(mac_mode_e mode, int lanes);
        case (mode)
            MAC_SINGLE: return 1;
            MAC_DUAL:   return 2;
            MAC_QUAD:   return 4;
            default:    return lanes;
        endcase
    endfunction

endpackage

// File: rtl/mac_block_gen_if.sv
// ----------------------------------------------------------------------------
// mac_block_gen_if
// Operand / result bus of one MAC slice.
//   in_valid/in_ready  operand beat handshake (a lanes, shared b, group config)
//   out_valid/out_ready result handshake (out_data, out_last, out_ovf)
// Modports: master = operand fetch + result collector side, slave = slice.
// ----------------------------------------------------------------------------
interface mac_block_gen_if
    import mac_pkg::*;
#(
    parameter int MIN_W = MAC_MIN_W,
    parameter int LANES = MAC_LANES,
    parameter int ACC_W = MAC_ACC_W,
    parameter int CNT_W = MAC_CNT_W
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*MIN_W-1:0] a;
    logic [MIN_W-1:0]       b;
    logic [1:0]             cfg_mode;
    logic                   cfg_acc_en;
    logic [CNT_W-1:0]       acc_len;
    logic [ACC_W-1:0]       init_val;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic                   out_last;
    logic                   out_ovf;

    modport master (
        output in_valid, a, b, cfg_mode, cfg_acc_en, acc_len, init_val, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ovf
    );

    modport slave (
        input  in_valid, a, b, cfg_mode, cfg_acc_en, acc_len, init_val, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ovf
    );
endinterface

// File: rtl/mac_lane_pack.sv
// ----------------------------------------------------------------------------
// mac_lane_pack
// Combinational LANES x (a_i * b) multipliers and mode packing. The top k
// lanes (k from mode) are summed with lane LANES-k+j shifted by j*MIN_W.
//   a_i    in  LANES*MIN_W  A lanes
//   b_i    in  MIN_W        shared B operand
//   mode_i in  mac_mode_e   packing mode
//   prod_o out INT_W        packed product
// ----------------------------------------------------------------------------
module mac_lane_pack
    import mac_pkg::*;
#(
    parameter int MIN_W = MAC_MIN_W,
    parameter int LANES = MAC_LANES,
    parameter int INT_W = (LANES + 1) * MIN_W
) (
    input  logic [LANES*MIN_W-1:0] a_i,
    input  logic [MIN_W-1:0]       b_i,
    input  mac_mode_e              mode_i,
    output logic [INT_W-1:0]       prod_o
);
    logic [LANES-1:0][2*MIN_W-1:0] p;
    int                            k;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
        assign p[gi] = (2*MIN_W)'(a_i[gi*MIN_W +: MIN_W]) * (2*MIN_W)'(b_i);
    end

    // Adjacent products overlap by MIN_W bits; INT_W is wide enough that
    // the overlapping sum never carries out.
    always_comb begin
        k      = mode_lanes(mode_i, LANES);
        prod_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i >= LANES - k)
                prod_o = prod_o + (INT_W'(p[i]) << ((i - (LANES - k)) * MIN_W));
        end
    end
endmodule

// File: rtl/mac_block_gen.sv
// ----------------------------------------------------------------------------
// mac_block_gen
// MAC slice: packed lane products, 2-stage pipe with valid/ready, and a group
// accumulator emitting one result per acc_len beats (0 treated as 1).
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-low reset
//   bus  slave modport of mac_block_gen_if (operand beats in, results out)
// Build option: MAC_SAT_EN -- saturate group sums at 2^ACC_W-1 and flag
// out_ovf; when undefined sums wrap and out_ovf is 0.
// ----------------------------------------------------------------------------
module mac_block_gen
    import mac_pkg::*;
#(
    parameter int MIN_W = MAC_MIN_W,
    parameter int LANES = MAC_LANES,
    parameter int ACC_W = MAC_ACC_W,
    parameter int CNT_W = MAC_CNT_W
) (
    input logic          clk,
    input logic          rst,
    mac_block_gen_if.slave bus
);
    localparam int INT_W = (LANES + 1) * MIN_W;

    logic             ready_q, advance, accept, beat_last;
    // Group configuration is latched at the first accepted beat so that
    // packing and accumulation see consistent settings for the whole group.
    logic             grp_open_q, grp_open_d, grp_acc_q;
    mac_mode_e        grp_mode_q, mode_eff;
    logic [CNT_W-1:0] grp_len_q, cnt_q, cnt_d, cnt_inc, len_raw, len_eff;
    logic [ACC_W-1:0] grp_init_q, init_eff;
    logic             acc_eff;
    logic [INT_W-1:0] prod;

    logic             s1_valid_q, s1_acc_q, s1_first_q, s1_last_q;
    logic [INT_W-1:0] s1_prod_q;
    logic [ACC_W-1:0] s1_init_q;

    logic [ACC_W-1:0] acc_q, base, res, out_data_q;
    logic             ovf_grp, out_valid_q, out_last_q, out_ovf_q;

    assign advance      = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = advance & ready_q;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        mode_eff   = grp_open_q ? grp_mode_q : mac_mode_e'(bus.cfg_mode);
        acc_eff    = grp_open_q ? grp_acc_q  : bus.cfg_acc_en;
        len_raw    = grp_open_q ? grp_len_q  : bus.acc_len;
        init_eff   = grp_open_q ? grp_init_q : bus.init_val;
        len_eff    = (len_raw == '0) ? CNT_W'(1) : len_raw;
        cnt_inc    = (grp_open_q ? cnt_q : '0) + CNT_W'(1);
        beat_last  = (cnt_inc == len_eff);
        grp_open_d = grp_open_q;
        cnt_d      = cnt_q;
        if (accept && acc_eff) begin
            grp_open_d = ~beat_last;
            cnt_d      = beat_last ? '0 : cnt_inc;
        end
    end

    mac_lane_pack #(.MIN_W(MIN_W), .LANES(LANES), .INT_W(INT_W)) u_pack (
        .a_i    (bus.a),
        .b_i    (bus.b),
        .mode_i (mode_eff),
        .prod_o (prod)
    );

    // ready_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q    <= 1'b0;
            grp_open_q <= 1'b0;
            cnt_q      <= '0;
            grp_acc_q  <= 1'b0;
            grp_mode_q <= MAC_SINGLE;
            grp_len_q  <= '0;
            grp_init_q <= '0;
            s1_valid_q <= 1'b0;
            s1_acc_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
            s1_init_q  <= '0;
        end else begin
            ready_q    <= 1'b1;
            grp_open_q <= grp_open_d;
            cnt_q      <= cnt_d;
            if (accept && !grp_open_q) begin
                grp_acc_q  <= bus.cfg_acc_en;
                grp_mode_q <= mac_mode_e'(bus.cfg_mode);
                grp_len_q  <= bus.acc_len;
                grp_init_q <= bus.init_val;
            end
            if (advance) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_prod_q  <= prod;
                    s1_acc_q   <= acc_eff;
                    s1_first_q <= ~grp_open_q;
                    s1_last_q  <= beat_last;
                    s1_init_q  <= init_eff;
                end
            end
        end
    end

    assign base = s1_first_q ? s1_init_q : acc_q;

`ifdef MAC_SAT_EN
    logic [ACC_W:0] sum_w;
    logic           ovf_acc_q;

    always_comb begin
        sum_w   = {1'b0, base} + (ACC_W+1)'(s1_prod_q);
        res     = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
        ovf_grp = (~s1_first_q & ovf_acc_q) | sum_w[ACC_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf_acc_q <= 1'b0;
        else if (advance && s1_valid_q && s1_acc_q)
            ovf_acc_q <= ovf_grp;
    end
`else
    assign res     = base + ACC_W'(s1_prod_q);
    assign ovf_grp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (advance) begin
            if (s1_valid_q && !s1_acc_q) begin
                out_data_q  <= ACC_W'(s1_prod_q);
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
                out_ovf_q   <= 1'b0;
            end else if (s1_valid_q) begin
                acc_q <= res;
                if (s1_last_q) begin
                    out_data_q  <= res;
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b1;
                    out_ovf_q   <= ovf_grp;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mac_block_gen.sv
// ----------------------------------------------------------------------------
// tb_mac_block_gen
// Table of single-result vectors, hand sequences for groups, backpressure and
// reset, then random traffic against a scoreboard model of the slice.
// ----------------------------------------------------------------------------
module tb_mac_block_gen;
    import mac_pkg::*;

    localparam int MIN_W = 8;
    localparam int LANES = 4;
    localparam int ACC_W = 48;
    localparam int CNT_W = 8;
    localparam longint unsigned MOD = 64'h1_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_block_gen_if #(.MIN_W(MIN_W), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mac_block_gen #(.MIN_W(MIN_W), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        bit              acc;
        logic [1:0]      mode;
        logic [7:0]      len;
        logic [47:0]     init;
        logic [31:0]     a;
        logic [7:0]      b;
        longint unsigned exp_data;
        bit              exp_last;
        bit              exp_ovf;
    } vec_t;

    typedef struct {
        longint unsigned data;
        bit              last;
        bit              ovf;
    } res_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   n0;
    res_t expq[$];
    res_t last_out, held, e;
    bit   hold_prev = 0;
    bit   rnd_on;
    vec_t tbl[8];

    // reference model state: one open group at most
    bit              m_open = 0;
    bit              m_acc;
    logic [1:0]      m_mode;
    logic [7:0]      m_len;
    longint unsigned m_init, m_sum;
    bit              m_ovf;
    int              m_cnt;

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_beat(bit acc, logic [1:0] mode, logic [7:0] len,
                                       logic [47:0] init, logic [31:0] a, logic [7:0] b);
        int k;
        longint unsigned prod, lane;
        res_t r;
        if (!m_open) begin
            m_acc = acc; m_mode = mode; m_len = len; m_init = init;
        end
        k = (m_mode == 2'd0) ? 1 : (m_mode == 2'd1) ? 2 : (m_mode == 2'd2) ? 4 : LANES;
        prod = 0;
        for (int j = 0; j < k; j++) begin
            lane = (a >> (8 * (LANES - k + j))) & 32'hFF;
            prod += (lane * b) << (8 * j);
        end
        if (!m_acc) begin
            r.data = prod; r.last = 0; r.ovf = 0;
            expq.push_back(r);
            return;
        end
        if (!m_open) begin
            m_open = 1; m_sum = m_init; m_ovf = 0; m_cnt = 0;
        end
        m_sum += prod;
        if (m_sum >= MOD) begin
`ifdef MAC_SAT_EN
            m_sum = MOD - 1;
            m_ovf = 1;
`else
            m_sum -= MOD;
`endif
        end
        m_cnt++;
        if (m_cnt == ((m_len == 0) ? 1 : int'(m_len))) begin
            r.data = m_sum; r.last = 1; r.ovf = m_ovf;
            expq.push_back(r);
            m_open = 0;
        end
    endfunction

    task automatic send(bit acc, logic [1:0] mode, logic [7:0] len, logic [47:0] init,
                        logic [31:0] a, logic [7:0] b);
        @(posedge clk); #1;
        bus.in_valid = 1; bus.cfg_acc_en = acc; bus.cfg_mode = mode;
        bus.acc_len = len; bus.init_val = init; bus.a = a; bus.b = b;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_beat(acc, mode, len, init, a, b);
                @(posedge clk); #1;
                bus.in_valid = 0;
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: got in_ready 0 want 1");
        bus.in_valid = 0;
    endtask

    task automatic wait_out(int target, string name);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (n_out >= target) return;
        end
        n_cmp++; n_fail++;
        $display("FAIL %s_timeout: got %0d outputs want %0d", name, n_out, target);
    endtask

    task automatic wait_drain(string name);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk); #1;
            if (expq.size() == 0) return;
        end
        chk({name, "_drain"}, expq.size(), 0);
    endtask

    // output monitor: scoreboard, and stability while stalled
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", bus.out_valid, 1);
                if (bus.out_valid) begin
                    chk("hold_data", bus.out_data, held.data);
                    chk("hold_last", bus.out_last, held.last);
                    chk("hold_ovf", bus.out_ovf, held.ovf);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL spurious_out: got 0x%0h want no output", bus.out_data);
                end else begin
                    e = expq.pop_front();
                    chk("sb_data", bus.out_data, e.data);
                    chk("sb_last", bus.out_last, e.last);
                    chk("sb_ovf", bus.out_ovf, e.ovf);
                end
                last_out.data = bus.out_data;
                last_out.last = bus.out_last;
                last_out.ovf  = bus.out_ovf;
                n_out++;
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            held.data = bus.out_data;
            held.last = bus.out_last;
            held.ovf  = bus.out_ovf;
        end
    end

    initial begin
        bus.in_valid = 0; bus.out_ready = 1; bus.a = 0; bus.b = 0;
        bus.cfg_mode = 0; bus.cfg_acc_en = 0; bus.acc_len = 0; bus.init_val = 0;

        tbl[0] = '{0, 2'd0, 8'd0, 48'd0,   32'hFF00_0000, 8'hFF, 64'hFE01,         0, 0};
        tbl[1] = '{0, 2'd2, 8'd0, 48'd0,   32'h0403_0201, 8'h02, 64'h0806_0402,    0, 0};
        tbl[2] = '{0, 2'd1, 8'd0, 48'd0,   32'h0403_0201, 8'h02, 64'h0806,         0, 0};
        tbl[3] = '{0, 2'd3, 8'd0, 48'd0,   32'hFFFF_FFFF, 8'hFF, 64'hFE_FFFF_FF01, 0, 0};
        tbl[4] = '{1, 2'd0, 8'd1, 48'd10,  32'h0500_0000, 8'h03, 64'd25,           1, 0};
        tbl[5] = '{1, 2'd1, 8'd0, 48'd100, 32'h0203_0000, 8'h01, 64'h267,          1, 0};
`ifdef MAC_SAT_EN
        tbl[6] = '{1, 2'd0, 8'd1, 48'hFFFF_FFFF_FFFE, 32'h0500_0000, 8'h01, 64'hFFFF_FFFF_FFFF, 1, 1};
`else
        tbl[6] = '{1, 2'd0, 8'd1, 48'hFFFF_FFFF_FFFE, 32'h0500_0000, 8'h01, 64'd3, 1, 0};
`endif
        tbl[7] = '{0, 2'd0, 8'd0, 48'd0,   32'h00FF_FFFF, 8'hFF, 64'd0,            0, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rel_in_ready_early", bus.in_ready, 0);
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1);

        // single-result vectors, latency 2 from accept
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].acc, tbl[i].mode, tbl[i].len, tbl[i].init, tbl[i].a, tbl[i].b);
            @(negedge clk);
            chk($sformatf("v%0d_early_valid", i), bus.out_valid, 0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("v%0d_data", i), bus.out_data, tbl[i].exp_data);
            chk($sformatf("v%0d_last", i), bus.out_last, tbl[i].exp_last);
            chk($sformatf("v%0d_ovf", i), bus.out_ovf, tbl[i].exp_ovf);
        end

        // 3-beat group; mid-group config changes must be ignored
        n0 = n_out;
        send(1, 2'd0, 8'd3, 48'd10,  32'h0500_0000, 8'd1);
        send(1, 2'd2, 8'd1, 48'd999, 32'h0600_0000, 8'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("grp_no_early", n_out, n0);
        send(1, 2'd2, 8'd1, 48'd999, 32'h0700_0000, 8'd1);
        wait_out(n0 + 1, "grp");
        chk("grp_data", last_out.data, 28);
        chk("grp_last", last_out.last, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("grp_count", n_out, n0 + 1);

        // backpressure over a stream of pass beats
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(0, 2'(i % 4), 8'd0, 48'd0, $urandom, 8'($urandom_range(1, 255)));
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 0;
                repeat (2) @(negedge clk);
                chk("bp_in_ready", bus.in_ready, 0);
                chk("bp_out_valid", bus.out_valid, 1);
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        wait_drain("bp");
        chk("bp_count", n_out, n0 + 8);

        // reset in the middle of a group
        send(1, 2'd0, 8'd3, 48'd7, 32'h0100_0000, 8'd1);
        send(1, 2'd0, 8'd3, 48'd7, 32'h0200_0000, 8'd1);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_last", bus.out_last, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        m_open = 0;
        expq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        n0 = n_out;
        send(1, 2'd0, 8'd2, 48'd50, 32'h0100_0000, 8'd1);
        send(1, 2'd0, 8'd2, 48'd50, 32'h0200_0000, 8'd1);
        wait_out(n0 + 1, "post_rst");
        chk("post_rst_data", last_out.data, 53);
        chk("post_rst_last", last_out.last, 1);

        // random traffic against the model
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [47:0] ini;
                    if ($urandom_range(0, 3) == 0)
                        ini = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 1000));
                    else
                        ini = {16'($urandom), 32'($urandom)};
                    send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         8'($urandom_range(0, 4)), ini, $urandom, 8'($urandom_range(0, 255)));
                    if ($urandom_range(0, 3) == 0) @(posedge clk);
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 9) < 7);
                end
                bus.out_ready = 1;
            end
        join
        wait_drain("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
